// File: rtl/mem_stage_lsu_pkg.sv
// Shared decode constants and LSU state type for the MEM stage.
// Contents:
//   - opcode / funct3 / funct7 localparams for the RV32 subset the MEM stage decodes
//   - lsu_state_e : data-memory handshake states
//   - writes_rd() : opcodes that write the register file
package mem_stage_lsu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_e;

  // True for opcodes whose result is written back to rd.
  function automatic logic writes_rd(input logic [6:0] opc);
    logic w;
    case (opc)
      OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM: w = 1'b1;
      default:                                  w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_chk.sv
// Protocol checker for the data-memory port of mem_stage_lsu.
// A response must never arrive in the same cycle a request is being granted.
// Ports: clk, rst (sync active-low), dm_req, dm_gnt, dm_rvalid (all observed only).
module mem_stage_lsu_chk (
  input logic clk,
  input logic rst,
  input logic dm_req,
  input logic dm_gnt,
  input logic dm_rvalid
);

  // Grant and load-data-valid overlapping on an outstanding request is illegal.
  a_no_gnt_with_rvalid : assert property (@(posedge clk) disable iff (!rst)
    !(dm_req && dm_gnt && dm_rvalid))
    else $error("dm_gnt and dm_rvalid asserted together during a request");

endmodule

// File: rtl/mem_stage_lsu_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a memory word
// and sign- or zero-extends it according to the load funct3.
// Ports:
//   rdata   in  32  raw word from data memory
//   addr_lo in  2   low address bits of the load
//   funct3  in  3   load width/sign selector
//   data    out 32  aligned, extended load value
module mem_stage_lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel_s;
  logic [15:0] half_sel_s;

  // Lane select followed by extension; halfword uses addr_lo[1] only.
  always_comb begin
    byte_sel_s = 8'h00;
    half_sel_s = 16'h0000;
    data       = rdata;
    case (addr_lo)
      2'b00:   byte_sel_s = rdata[7:0];
      2'b01:   byte_sel_s = rdata[15:8];
      2'b10:   byte_sel_s = rdata[23:16];
      2'b11:   byte_sel_s = rdata[31:24];
      default: byte_sel_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_sel_s = rdata[31:16];
    end else begin
      half_sel_s = rdata[15:0];
    end
    case (funct3)
      F3_B:    data = {{24{byte_sel_s[7]}}, byte_sel_s};
      F3_H:    data = {{16{half_sel_s[15]}}, half_sel_s};
      F3_BU:   data = {24'h000000, byte_sel_s};
      F3_HU:   data = {16'h0000, half_sel_s};
      F3_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with load/store unit.
// Consumes the EXE/MEM register outputs, runs the data-memory req/gnt/rvalid
// handshake, stalls the pipeline while an access is outstanding and registers
// the write-back result into MEM/WB.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   alu_out_M/rs2_data_M/mul_M/csr_M/inst_M   MEM-stage operands and instruction
//   stall_ext                      stall from elsewhere (holds EXE/MEM and MEM/WB)
//   stall_mem                      this stage needs the pipeline held
//   dm_req/dm_we/dm_addr/dm_wstrb/dm_wdata    data-memory request
//   dm_gnt/dm_rvalid/dm_rdata      data-memory grant and load response
//   wb_data/wb_rd/wb_we/inst_W     MEM/WB register
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   alu_out_M,
  input  logic [XLEN-1:0]   rs2_data_M,
  input  logic [XLEN-1:0]   mul_M,
  input  logic [XLEN-1:0]   csr_M,
  input  logic [31:0]       inst_M,
  input  logic              stall_ext,
  output logic              stall_mem,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wstrb,
  output logic [XLEN-1:0]   dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [XLEN-1:0]   dm_rdata,
  output logic [XLEN-1:0]   wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic [31:0]       inst_W
);

  lsu_state_e      state_r, state_nxt_s;
  logic            done_r, done_nxt_s;
  logic [XLEN-1:0] load_q_r;

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [4:0]      rd_s;
  logic            is_load_s, is_store_s, is_sys_s, is_mul_s, mem_op_s;
  logic            issue_s, complete_s, capture_s, busy_s, advance_s;
  logic [XLEN-1:0] ld_raw_s, ld_data_s, wb_sel_s;
  logic            wb_we_s;
  logic [3:0]      wstrb_s;
  logic [XLEN-1:0] wdata_s;

  assign opcode_s   = inst_M[6:0];
  assign funct3_s   = inst_M[14:12];
  assign rd_s       = inst_M[11:7];
  assign is_load_s  = (opcode_s == OPC_LOAD);
  assign is_store_s = (opcode_s == OPC_STORE);
  assign is_sys_s   = (opcode_s == OPC_SYSTEM);
  assign is_mul_s   = (opcode_s == OPC_OP) && (inst_M[31:25] == F7_MULDIV);
  assign mem_op_s   = is_load_s || is_store_s;

  // Handshake next-state. The IDLE cycle that starts an access already drives
  // dm_req, so a grant there is handled exactly like a grant in REQ.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    complete_s  = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_op_s && !done_r) begin
          issue_s = 1'b1;
          if (dm_gnt) begin
            if (is_store_s) begin
              complete_s  = 1'b1;
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = WAIT;
            end
          end else begin
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        issue_s = 1'b1;
        if (dm_gnt) begin
          if (is_store_s) begin
            complete_s  = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (dm_rvalid) begin
          complete_s  = 1'b1;
          capture_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // The completing cycle does not stall: store data is gone, load data is bypassed.
  assign busy_s    = (state_r != IDLE) || (mem_op_s && !done_r);
  assign stall_mem = rst && busy_s && !complete_s;
  assign dm_req    = rst && issue_s;
  assign dm_we     = dm_req && is_store_s;
  assign dm_addr   = {alu_out_M[ADDR_W-1:2], 2'b00};
  assign advance_s = !stall_ext && !stall_mem;

  // done marks an access already performed for the instruction held in MEM,
  // so a stall_ext hold cannot re-issue it; cleared once the instruction leaves.
  always_comb begin
    done_nxt_s = done_r;
    if (advance_s) begin
      done_nxt_s = 1'b0;
    end else if (complete_s) begin
      done_nxt_s = 1'b1;
    end else begin
      done_nxt_s = done_r;
    end
  end

  // Handshake state, done flag and captured load word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      done_r   <= 1'b0;
      load_q_r <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_nxt_s;
      if (capture_s) begin
        load_q_r <= dm_rdata;
      end
    end
  end

  // Store byte lanes and replicated write data.
  always_comb begin
    wstrb_s = 4'b0000;
    wdata_s = {XLEN{1'b0}};
    if (is_store_s) begin
      case (funct3_s)
        F3_B: begin
          wstrb_s = 4'b0001 << alu_out_M[1:0];
          wdata_s = {4{rs2_data_M[7:0]}};
        end
        F3_H: begin
          wstrb_s = alu_out_M[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{rs2_data_M[15:0]}};
        end
        F3_W: begin
          wstrb_s = 4'b1111;
          wdata_s = rs2_data_M;
        end
        default: begin
          wstrb_s = 4'b0000;
          wdata_s = rs2_data_M;
        end
      endcase
    end else begin
      wstrb_s = 4'b0000;
      wdata_s = {XLEN{1'b0}};
    end
  end

  assign dm_wstrb = wstrb_s;
  assign dm_wdata = wdata_s;

  // Bypass the response word in its arrival cycle, otherwise use the captured copy.
  assign ld_raw_s = capture_s ? dm_rdata : load_q_r;

  mem_stage_lsu_load_align u_load_align (
    .rdata   (ld_raw_s),
    .addr_lo (alu_out_M[1:0]),
    .funct3  (funct3_s),
    .data    (ld_data_s)
  );

  // Write-back source select.
  always_comb begin
    wb_sel_s = alu_out_M;
    if (is_load_s) begin
      wb_sel_s = ld_data_s;
    end else if (is_sys_s) begin
      wb_sel_s = csr_M;
    end else if (is_mul_s) begin
      wb_sel_s = mul_M;
    end else begin
      wb_sel_s = alu_out_M;
    end
  end

  assign wb_we_s = (rd_s != 5'd0) && writes_rd(opcode_s);

  // MEM/WB register: load on advance, bubble when only this stage stalls, hold on stall_ext.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_data <= {XLEN{1'b0}};
      wb_rd   <= 5'd0;
      wb_we   <= 1'b0;
      inst_W  <= 32'h0000_0000;
    end else if (advance_s) begin
      wb_data <= wb_sel_s;
      wb_rd   <= rd_s;
      wb_we   <= wb_we_s;
      inst_W  <= inst_M;
    end else if (!stall_ext) begin
      wb_data <= {XLEN{1'b0}};
      wb_rd   <= 5'd0;
      wb_we   <= 1'b0;
      inst_W  <= 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_SYS = 7'b1110011;
  localparam logic [6:0] O_OP = 7'b0110011, O_OPI = 7'b0010011, O_LUI = 7'b0110111;
  localparam logic [6:0] O_BR = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_out_M, rs2_data_M, mul_M, csr_M, inst_M;
  logic        stall_ext, stall_mem, dm_req, dm_we, dm_gnt, dm_rvalid, wb_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, wb_data, inst_W;
  logic [3:0]  dm_wstrb;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] prev_data, prev_inst;
  logic        prev_we;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .alu_out_M(alu_out_M), .rs2_data_M(rs2_data_M),
    .mul_M(mul_M), .csr_M(csr_M), .inst_M(inst_M), .stall_ext(stall_ext),
    .stall_mem(stall_mem), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .inst_W(inst_W)
  );

  mem_stage_lsu_chk u_chk (
    .clk(clk), .rst(rst), .dm_req(dm_req), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid)
  );

  typedef struct {
    logic [31:0] inst, alu, rs2, mul, csr, rdata;
    int          gd, rvd;
    bit          hold;
    logic [31:0] e_data;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [4:0] rd);
    return {f7, 10'd0, f3, rd, opc};
  endfunction

  // Reference model: plain arithmetic on the architectural rules.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
    h = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_wb(input vec_t v);
    if (v.inst[6:0] == O_LOAD) return ref_load(v.inst[14:12], v.alu, v.rdata);
    if (v.inst[6:0] == O_SYS) return v.csr;
    if (v.inst[6:0] == O_OP && v.inst[31:25] == 7'd1) return v.mul;
    return v.alu;
  endfunction

  function automatic logic ref_we(input logic [31:0] inst);
    return (inst[11:7] != 5'd0) && (inst[6:0] inside {O_LOAD, O_OP, O_OPI, O_LUI,
            7'b0010111, 7'b1101111, 7'b1100111, O_SYS});
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] inst, input logic [31:0] a);
    if (inst[6:0] != O_STORE) return 4'h0;
    case (inst[14:12])
      3'd0:    return 4'b0001 << int'(a[1:0]);
      3'd1:    return 4'b0011 << (2 * int'(a[1]));
      3'd2:    return 4'b1111;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] inst, input logic [31:0] d);
    case (inst[14:12])
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Applies one instruction, plays the memory side, checks every cycle and the final write-back.
  task automatic exec_op(input vec_t v);
    bit ld, st;
    ld = (v.inst[6:0] == O_LOAD);
    st = (v.inst[6:0] == O_STORE);
    inst_M = v.inst; alu_out_M = v.alu; rs2_data_M = v.rs2; mul_M = v.mul; csr_M = v.csr;
    stall_ext = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    if (ld || st) begin
      for (int c = 0; c <= v.gd; c++) begin
        dm_gnt = (c == v.gd);
        #4;
        chk1("dm_req", dm_req, 1'b1);
        chk1("dm_we", dm_we, st);
        chk("dm_addr", dm_addr, v.alu & 32'hFFFF_FFFC);
        chk("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, v.e_strb});
        if (st) chk("dm_wdata", dm_wdata, v.e_wdata);
        chk1("stall_mem_req", stall_mem, ld || (c != v.gd));
        @(posedge clk); #1;
        dm_gnt = 1'b0;
        if (ld || c != v.gd) begin
          chk("bubble_inst_W", inst_W, 32'h0);
          chk1("bubble_wb_we", wb_we, 1'b0);
        end
      end
      if (ld) begin
        for (int c = 1; c <= v.rvd; c++) begin
          dm_rvalid = (c == v.rvd);
          dm_rdata  = (c == v.rvd) ? v.rdata : $urandom();
          #4;
          chk1("dm_req_wait", dm_req, 1'b0);
          chk1("stall_mem_wait", stall_mem, c != v.rvd);
          @(posedge clk); #1;
          dm_rvalid = 1'b0;
          if (c != v.rvd) chk("bubble_wait_inst_W", inst_W, 32'h0);
        end
      end
    end else begin
      if (v.hold) begin
        stall_ext = 1'b1;
        #4;
        chk1("stall_mem_hold", stall_mem, 1'b0);
        @(posedge clk); #1;
        chk("hold_wb_data", wb_data, prev_data);
        chk("hold_inst_W", inst_W, prev_inst);
        chk1("hold_wb_we", wb_we, prev_we);
        stall_ext = 1'b0;
      end
      #4;
      chk1("stall_mem_alu", stall_mem, 1'b0);
      chk1("dm_req_alu", dm_req, 1'b0);
      @(posedge clk); #1;
    end
    chk("wb_data", wb_data, v.e_data);
    chk1("wb_we", wb_we, v.e_we);
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, v.inst[11:7]});
    chk("inst_W", inst_W, v.inst);
    prev_data = v.e_data; prev_inst = v.inst; prev_we = v.e_we;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    int   reqs, gnts, k;
    logic [2:0] ldf3 [5];

    ldf3[0] = 3'd0; ldf3[1] = 3'd1; ldf3[2] = 3'd2; ldf3[3] = 3'd4; ldf3[4] = 3'd5;

    //          inst                      alu           rs2           mul    csr   rdata         gd rvd hold e_data        we    strb   wdata
    tbl[0]  = '{mk(O_STORE, 3'd2, 7'd0, 5'd0), 32'h100, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0,         2, 1, 1'b0, 32'h100,      1'b0, 4'hF, 32'hDEADBEEF};
    tbl[1]  = '{mk(O_LOAD,  3'd0, 7'd0, 5'd1), 32'h103, 32'd0,        32'd0, 32'd0, 32'h80FF0000,  0, 1, 1'b0, 32'hFFFFFF80, 1'b1, 4'h0, 32'h0};
    tbl[2]  = '{mk(O_LOAD,  3'd4, 7'd0, 5'd2), 32'h103, 32'd0,        32'd0, 32'd0, 32'h80FF0000,  0, 1, 1'b0, 32'h00000080, 1'b1, 4'h0, 32'h0};
    tbl[3]  = '{mk(O_STORE, 3'd1, 7'd0, 5'd0), 32'h102, 32'h1234,     32'd0, 32'd0, 32'd0,         1, 1, 1'b0, 32'h102,      1'b0, 4'hC, 32'h12341234};
    tbl[4]  = '{mk(O_LOAD,  3'd1, 7'd0, 5'd3), 32'h102, 32'd0,        32'd0, 32'd0, 32'h80010000,  0, 2, 1'b0, 32'hFFFF8001, 1'b1, 4'h0, 32'h0};
    tbl[5]  = '{mk(O_OP,    3'd0, 7'd0, 5'd5), 32'd7,   32'd0,        32'd0, 32'd0, 32'd0,         0, 1, 1'b0, 32'd7,        1'b1, 4'h0, 32'h0};
    tbl[6]  = '{mk(O_OP,    3'd0, 7'd1, 5'd6), 32'h55,  32'd0,        32'd42,32'd0, 32'd0,         0, 1, 1'b0, 32'd42,       1'b1, 4'h0, 32'h0};
    tbl[7]  = '{mk(O_SYS,   3'd2, 7'd0, 5'd7), 32'h66,  32'd0,        32'd0, 32'd9, 32'd0,         0, 1, 1'b0, 32'd9,        1'b1, 4'h0, 32'h0};
    tbl[8]  = '{mk(O_OP,    3'd0, 7'd0, 5'd0), 32'h77,  32'd0,        32'd0, 32'd0, 32'd0,         0, 1, 1'b0, 32'h77,       1'b0, 4'h0, 32'h0};
    tbl[9]  = '{mk(O_LOAD,  3'd5, 7'd0, 5'd8), 32'h100, 32'd0,        32'd0, 32'd0, 32'h1234F00D,  1, 3, 1'b0, 32'h0000F00D, 1'b1, 4'h0, 32'h0};
    tbl[10] = '{mk(O_STORE, 3'd0, 7'd0, 5'd0), 32'h101, 32'hAB,       32'd0, 32'd0, 32'd0,         0, 1, 1'b0, 32'h101,      1'b0, 4'h2, 32'hABABABAB};
    tbl[11] = '{mk(O_OPI,   3'd0, 7'd0, 5'd11),32'h123, 32'd0,        32'd0, 32'd0, 32'd0,         0, 1, 1'b1, 32'h123,      1'b1, 4'h0, 32'h0};

    // Reset with a load sitting in MEM: nothing may be requested.
    rst = 1'b0; inst_M = mk(O_LOAD, 3'd2, 7'd0, 5'd4); alu_out_M = 32'h40;
    rs2_data_M = 32'h0; mul_M = 32'h0; csr_M = 32'h0; stall_ext = 1'b0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'h0);
    chk1("rst_wb_we", wb_we, 1'b0);
    chk("rst_inst_W", inst_W, 32'h0);
    chk1("rst_dm_req", dm_req, 1'b0);
    chk1("rst_stall_mem", stall_mem, 1'b0);
    inst_M = 32'h0; alu_out_M = 32'h0; rst = 1'b1;
    @(posedge clk); #1;
    prev_data = 32'h0; prev_inst = 32'h0; prev_we = 1'b0;

    foreach (tbl[i]) exec_op(tbl[i]);

    // LW completes while stall_ext holds the pipeline for three cycles.
    inst_M = mk(O_LOAD, 3'd2, 7'd0, 5'd9); alu_out_M = 32'h200; stall_ext = 1'b1;
    reqs = 0; gnts = 0;
    for (int c = 0; c < 3; c++) begin
      dm_gnt = (c == 0); dm_rvalid = (c == 1);
      dm_rdata = (c == 1) ? 32'hCAFEF00D : 32'h0;
      #4;
      if (dm_req) reqs++;
      if (dm_req && dm_gnt) gnts++;
      chk1("ext_stall_mem", stall_mem, c == 0);
      @(posedge clk); #1;
      chk("ext_hold_wb_data", wb_data, prev_data);
      chk("ext_hold_inst_W", inst_W, prev_inst);
    end
    stall_ext = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h1111_1111;
    #4;
    if (dm_req) reqs++;
    chk1("ext_release_stall", stall_mem, 1'b0);
    @(posedge clk); #1;
    chk("ext_req_count", reqs, 32'd1);
    chk("ext_gnt_count", gnts, 32'd1);
    chk("ext_wb_data", wb_data, 32'hCAFEF00D);
    chk1("ext_wb_we", wb_we, 1'b1);
    chk("ext_wb_rd", {27'd0, wb_rd}, 32'd9);

    // Reset while waiting for load data; the late response must be ignored.
    inst_M = mk(O_LOAD, 3'd2, 7'd0, 5'd10); alu_out_M = 32'h300; dm_gnt = 1'b1;
    #4;
    chk1("wrst_req", dm_req, 1'b1);
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    #4;
    chk1("wrst_wait_req", dm_req, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("wrst_dm_req", dm_req, 1'b0);
    chk1("wrst_stall", stall_mem, 1'b0);
    chk("wrst_wb_data", wb_data, 32'h0);
    chk("wrst_inst_W", inst_W, 32'h0);
    chk1("wrst_wb_we", wb_we, 1'b0);
    inst_M = 32'h0; alu_out_M = 32'h0; rst = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hBAD0BAD0;
    #4;
    chk1("late_rvalid_stall", stall_mem, 1'b0);
    chk1("late_rvalid_req", dm_req, 1'b0);
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    chk("late_rvalid_wb_data", wb_data, 32'h0);
    chk1("late_rvalid_wb_we", wb_we, 1'b0);
    prev_data = 32'h0; prev_inst = 32'h0; prev_we = 1'b0;

    // Randomized instruction stream against the reference model.
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 7);
      v.alu = $urandom(); v.rs2 = $urandom(); v.mul = $urandom();
      v.csr = $urandom(); v.rdata = $urandom();
      v.gd = $urandom_range(0, 3); v.rvd = $urandom_range(1, 3);
      v.hold = ($urandom_range(0, 3) == 0);
      case (k)
        0:       v.inst = mk(O_LOAD, ldf3[$urandom_range(0, 4)], 7'($urandom()), 5'($urandom()));
        1:       v.inst = mk(O_STORE, 3'($urandom_range(0, 2)), 7'($urandom()), 5'($urandom()));
        2:       v.inst = mk(O_SYS, 3'($urandom_range(1, 3)), 7'd0, 5'($urandom()));
        3:       v.inst = mk(O_OP, 3'($urandom()), 7'd1, 5'($urandom()));
        4:       v.inst = mk(O_OP, 3'($urandom()), ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 5'($urandom()));
        5:       v.inst = mk(O_OPI, 3'($urandom()), 7'($urandom()), 5'($urandom()));
        6:       v.inst = mk(O_LUI, 3'($urandom()), 7'($urandom()), 5'($urandom()));
        default: v.inst = mk(O_BR, 3'($urandom()), 7'($urandom()), 5'($urandom()));
      endcase
      v.e_data  = ref_wb(v);
      v.e_we    = ref_we(v.inst);
      v.e_strb  = ref_strb(v.inst, v.alu);
      v.e_wdata = ref_wdata(v.inst, v.rs2);
      exec_op(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
